// File: rtl/zueirai_io_port.sv
// Three 8-bit bidirectional GPIO ports behind a 16-entry register file, with
// two-flop pad synchronizers and sticky, enable/polarity-selectable edge flags on port A.
module zueirai_io_port (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] io_porta,
  inout  wire  [7:0] io_portb,
  inout  wire  [7:0] io_portc,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [7:0] int_io,
  output logic       int_any
);

  // Register bus: wr_en and rd_en are single-cycle strobes with no ready/stall.
  // A write takes effect on the edge where wr_en=1. A read captures the
  // pre-edge register value into rdata on the edge where rd_en=1, and rdata
  // holds it until the next rd_en. Both strobes may target one address in the
  // same cycle: the old value is read and the new value is written.
  localparam logic [3:0] ADDR_DIR_A      = 4'd0;
  localparam logic [3:0] ADDR_DIR_B      = 4'd1;
  localparam logic [3:0] ADDR_DIR_C      = 4'd2;
  localparam logic [3:0] ADDR_OUT_A      = 4'd3;
  localparam logic [3:0] ADDR_OUT_B      = 4'd4;
  localparam logic [3:0] ADDR_OUT_C      = 4'd5;
  localparam logic [3:0] ADDR_IN_A       = 4'd6;
  localparam logic [3:0] ADDR_IN_B       = 4'd7;
  localparam logic [3:0] ADDR_IN_C       = 4'd8;
  localparam logic [3:0] ADDR_EDGE_EN_A  = 4'd9;
  localparam logic [3:0] ADDR_EDGE_POL_A = 4'd10;
  localparam logic [3:0] ADDR_PEND_A     = 4'd11;

  logic [7:0] dir_a, dir_b, dir_c;
  logic [7:0] out_a, out_b, out_c;
  logic [7:0] s1_a, s1_b, s1_c;
  logic [7:0] s2_a, s2_b, s2_c;
  logic [7:0] edge_en_a, edge_pol_a, pend_a;
  logic [7:0] edge_hit, pend_clr, pend_next;
  logic [7:0] rd_mux;

  // Pad drivers: a bit is driven only while its direction bit is 1.
  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign io_porta[i] = dir_a[i] ? out_a[i] : 1'bz;
    assign io_portb[i] = dir_b[i] ? out_b[i] : 1'bz;
    assign io_portc[i] = dir_c[i] ? out_c[i] : 1'bz;
  end

  // Every pad is synchronized regardless of direction, so self-driven
  // transitions are visible to the edge detector like any external one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a <= '0;
      s1_b <= '0;
      s1_c <= '0;
      s2_a <= '0;
      s2_b <= '0;
      s2_c <= '0;
    end else begin
      s1_a <= io_porta;
      s1_b <= io_portb;
      s1_c <= io_portc;
      s2_a <= s1_a;
      s2_b <= s1_b;
      s2_c <= s1_c;
    end
  end

  always_comb begin
    edge_hit  = edge_en_a & ((edge_pol_a & s1_a & ~s2_a) | (~edge_pol_a & ~s1_a & s2_a));
    pend_clr  = (wr_en && (addr == ADDR_PEND_A)) ? wdata : 8'h00;
    // A detection in the same cycle as a clear wins, so no edge is lost.
    pend_next = (pend_a & ~pend_clr) | edge_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_a      <= '0;
      dir_b      <= '0;
      dir_c      <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_c      <= '0;
      edge_en_a  <= '0;
      edge_pol_a <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_DIR_A:      dir_a      <= wdata;
        ADDR_DIR_B:      dir_b      <= wdata;
        ADDR_DIR_C:      dir_c      <= wdata;
        ADDR_OUT_A:      out_a      <= wdata;
        ADDR_OUT_B:      out_b      <= wdata;
        ADDR_OUT_C:      out_c      <= wdata;
        ADDR_EDGE_EN_A:  edge_en_a  <= wdata;
        ADDR_EDGE_POL_A: edge_pol_a <= wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a <= '0;
    end else begin
      pend_a <= pend_next;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_DIR_A:      rd_mux = dir_a;
      ADDR_DIR_B:      rd_mux = dir_b;
      ADDR_DIR_C:      rd_mux = dir_c;
      ADDR_OUT_A:      rd_mux = out_a;
      ADDR_OUT_B:      rd_mux = out_b;
      ADDR_OUT_C:      rd_mux = out_c;
      ADDR_IN_A:       rd_mux = s2_a;
      ADDR_IN_B:       rd_mux = s2_b;
      ADDR_IN_C:       rd_mux = s2_c;
      ADDR_EDGE_EN_A:  rd_mux = edge_en_a;
      ADDR_EDGE_POL_A: rd_mux = edge_pol_a;
      ADDR_PEND_A:     rd_mux = pend_a;
      default:         rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_mux;
    end
  end

  assign int_io  = pend_a;
  assign int_any = |pend_a;

endmodule
